// File: rtl/writeback_unit_pkg.sv
// Shared pCPU definitions for the writeback stage.
// Provides the register-file geometry, the writeback buffer depth, the
// arbitration source encoding and a helper for scoreboard lookups.
package writeback_unit_pkg;

    localparam int NUM_REGS      = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int WB_FIFO_DEPTH = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Which producer wins the register-file write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

    // Register 0 is hardwired and therefore never reported busy.
    function automatic logic reg_busy(input logic [NUM_REGS-1:0] busy,
                                      input reg_addr_t           ra);
        return (ra != '0) && busy[ra];
    endfunction

endpackage

// File: rtl/writeback_unit_skid_fifo.sv
// wb_skid_fifo: small in-order buffer for long-latency writeback results.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   push_i            - write {push_rd_i, push_data_i} at the tail (ignored when full)
//   pop_i             - drop the head entry (ignored when empty)
//   full_o, empty_o   - occupancy flags, driven from registered state only
//   head_rd_o/_data_o - oldest entry, valid while !empty_o
module wb_skid_fifo
    import writeback_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [REG_ADDR_W-1:0] push_rd_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [REG_ADDR_W-1:0] head_rd_o,
    output logic [WIDTH-1:0]      head_data_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
    logic [WIDTH-1:0]      data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign head_rd_o   = rd_mem[rd_ptr_q];
    assign head_data_o = data_mem[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is not reset; the count alone decides what is valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            rd_mem[wr_ptr_q]   <= push_rd_i;
            data_mem[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: merges single-cycle ALU results and buffered long-latency
// results onto one registered register-file write port, and tracks which
// registers still await a long-latency result.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data     - ALU result, always accepted, highest priority
//   lsu_valid/lsu_rd/lsu_data     - long-latency result, accepted when lsu_ready
//   lsu_ready                     - buffer has room (registered state only)
//   issue_valid/issue_rd/issue_long - issuing instruction, marks rd busy if long
//   chk_ra0/chk_ra1, hazard       - source operands and combinational busy check
//   alu_hold                      - buffer full, ALU must stall next cycle
//   rf_we/rf_wa/rf_wd             - registered register-file write port
//   sb_err                        - sticky: long issue to a register already busy
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [WIDTH-1:0]      alu_data,
    input  logic                  lsu_valid,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [WIDTH-1:0]      lsu_data,
    output logic                  lsu_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_long,
    input  logic [REG_ADDR_W-1:0] chk_ra0,
    input  logic [REG_ADDR_W-1:0] chk_ra1,
    output logic                  hazard,
    output logic                  alu_hold,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_wa,
    output logic [WIDTH-1:0]      rf_wd,
    output logic                  sb_err
);

    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [WIDTH-1:0]      head_data;

    wb_src_e               sel_src;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [WIDTH-1:0]      sel_data;

    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_wa_q, rf_wa_d;
    logic [WIDTH-1:0]      rf_wd_q, rf_wd_d;

    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  sb_err_q, sb_err_d;
    logic                  set_en, clr_en;

    // Readiness depends only on registered occupancy, never on lsu_valid.
    assign lsu_ready = !fifo_full && !rst;
    assign alu_hold  = fifo_full && !rst;
    assign fifo_push = lsu_valid && lsu_ready;
    assign fifo_pop  = !alu_valid && !fifo_empty;

    wb_skid_fifo #(.WIDTH(WIDTH), .DEPTH(WB_FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_rd_i   (lsu_rd),
        .push_data_i (lsu_data),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_rd_o   (head_rd),
        .head_data_o (head_data)
    );

    // Write-port arbitration: ALU first, otherwise drain the buffer head.
    always_comb begin
        sel_src  = SRC_NONE;
        sel_rd   = '0;
        sel_data = '0;
        if (alu_valid) begin
            sel_src  = SRC_ALU;
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end else if (fifo_pop) begin
            sel_src  = SRC_FIFO;
            sel_rd   = head_rd;
            sel_data = head_data;
        end
    end

    // Writes to r0 are dropped; address/data hold their last real write.
    always_comb begin
        rf_we_d = (sel_src != SRC_NONE) && (sel_rd != '0);
        rf_wa_d = rf_we_d ? sel_rd   : rf_wa_q;
        rf_wd_d = rf_we_d ? sel_data : rf_wd_q;
    end

    // Scoreboard: a pop retires rd; a new long issue re-marks it and wins.
    // Re-issuing to a register whose result retires in the same cycle is a
    // legitimate reuse, so it does not raise sb_err.
    assign set_en = issue_valid && issue_long && (issue_rd != '0);
    assign clr_en = fifo_pop && (head_rd != '0);

    always_comb begin
        busy_d   = busy_q;
        sb_err_d = sb_err_q;
        if (clr_en) busy_d[head_rd] = 1'b0;
        if (set_en) begin
            busy_d[issue_rd] = 1'b1;
            if (busy_q[issue_rd] && !(clr_en && head_rd == issue_rd)) sb_err_d = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    assign hazard = reg_busy(busy_q, chk_ra0) || reg_busy(busy_q, chk_ra1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q  <= 1'b0;
            rf_wa_q  <= '0;
            rf_wd_q  <= '0;
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            rf_we_q  <= rf_we_d;
            rf_wa_q  <= rf_wa_d;
            rf_wd_q  <= rf_wd_d;
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign rf_we  = rf_we_q;
    assign rf_wa  = rf_wa_q;
    assign rf_wd  = rf_wd_q;
    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: reset checks, a table of ALU
// write vectors, hand-written multi-cycle sequences and a randomized run
// against a queue-based reference model.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, issue_valid, issue_long;
    logic [4:0]  alu_rd, lsu_rd, issue_rd, chk_ra0, chk_ra1;
    logic [31:0] alu_data, lsu_data;
    logic        lsu_ready, hazard, alu_hold, rf_we, sb_err;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    writeback_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .lsu_ready(lsu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_long(issue_long),
        .chk_ra0(chk_ra0), .chk_ra1(chk_ra1),
        .hazard(hazard), .alu_hold(alu_hold),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .sb_err(sb_err)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    bit          m_busy[32];
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic        m_sb;

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
        m_sb = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive, check combinational outputs, advance the model, clock,
    // then check registered outputs.
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic iv, input logic [4:0] ird, input logic il,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        bit          rdy, pop, set, sv;
        ent_t        h, e;
        logic [4:0]  srd;
        logic [31:0] sd;
        alu_valid = av;  alu_rd = ard;  alu_data = ad;
        lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ld;
        issue_valid = iv; issue_rd = ird; issue_long = il;
        chk_ra0 = ra0;   chk_ra1 = ra1;
        #1;
        rdy = (m_q.size() < 2);
        check("lsu_ready", lsu_ready, rdy);
        check("alu_hold", alu_hold, !rdy);
        check("hazard", hazard, (ra0 != 0 && m_busy[ra0]) || (ra1 != 0 && m_busy[ra1]));

        pop = !av && (m_q.size() > 0);
        sv  = 0;
        srd = '0;
        sd  = '0;
        h.rd = '0;
        h.data = '0;
        if (av) begin
            sv = 1; srd = ard; sd = ad;
        end else if (pop) begin
            h = m_q.pop_front();
            sv = 1; srd = h.rd; sd = h.data;
        end
        if (lv && rdy) begin
            e.rd = lrd; e.data = ld;
            m_q.push_back(e);
        end
        set = iv && il && (ird != 0);
        if (set && m_busy[ird] && !(pop && h.rd == ird)) m_sb = 1'b1;
        if (pop) m_busy[h.rd] = 1'b0;
        if (set) m_busy[ird] = 1'b1;
        m_busy[0] = 1'b0;
        m_we = sv && (srd != 0);
        if (m_we) begin
            m_wa = srd;
            m_wd = sd;
        end

        @(posedge clk);
        #1;
        check("rf_we", rf_we, m_we);
        check("rf_wa", rf_wa, m_wa);
        check("rf_wd", rf_wd, m_wd);
        check("sb_err", sb_err, m_sb);
    endtask

    task automatic idle(input logic [4:0] ra0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, ra0, 0);
    endtask

    // ---------------- ALU vector table ----------------
    typedef struct {
        logic        av;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_we;
        logic [4:0]  exp_wa;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vt[5];

    initial begin
        logic        av, lv, iv, il;
        logic [4:0]  ird;

        vt[0] = '{1'b1, 5'd5,  32'h1234_5678, 1'b1, 5'd5,  32'h1234_5678};
        vt[1] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 5'd5,  32'h1234_5678};
        vt[2] = '{1'b0, 5'd9,  32'h0000_0055, 1'b0, 5'd5,  32'h1234_5678};
        vt[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF};
        vt[4] = '{1'b1, 5'd1,  32'h0000_0000, 1'b1, 5'd1,  32'h0000_0000};

        // ---- reset state ----
        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_rd = 0; issue_long = 0;
        chk_ra0 = 5'd3; chk_ra1 = 5'd4;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_wa", rf_wa, 0);
        check("rst_rf_wd", rf_wd, 0);
        check("rst_sb_err", sb_err, 0);
        check("rst_lsu_ready", lsu_ready, 0);
        check("rst_alu_hold", alu_hold, 0);
        check("rst_hazard", hazard, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_lsu_ready", lsu_ready, 1);
        @(posedge clk);
        #1;

        // ---- table-driven ALU writes ----
        for (int i = 0; i < 5; i++) begin
            cycle(vt[i].av, vt[i].rd, vt[i].data, 0, 0, 0, 0, 0, 0, 0, 0);
            check("tbl_we", rf_we, vt[i].exp_we);
            check("tbl_wa", rf_wa, vt[i].exp_wa);
            check("tbl_wd", rf_wd, vt[i].exp_wd);
        end

        // ---- long result retires and clears hazard ----
        cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
        check("s_lsu_hazard_set", hazard, 1);
        cycle(0, 0, 0, 1, 5'd7, 32'hA5, 0, 0, 0, 5'd7, 0);
        idle(5'd7);
        check("s_lsu_we", rf_we, 1);
        check("s_lsu_wa", rf_wa, 7);
        check("s_lsu_wd", rf_wd, 32'hA5);
        check("s_lsu_hazard_clr", hazard, 0);

        // ---- ALU holds the port while the buffer fills ----
        cycle(1, 5'd2, 32'h111, 1, 5'd10, 32'hA0A0, 0, 0, 0, 0, 0);
        cycle(1, 5'd3, 32'h222, 1, 5'd11, 32'hB0B0, 0, 0, 0, 0, 0);
        check("s_full_ready", lsu_ready, 0);
        check("s_full_hold", alu_hold, 1);
        cycle(1, 5'd4, 32'h333, 1, 5'd12, 32'hC0C0, 0, 0, 0, 0, 0);
        check("s_full_alu_wd", rf_wd, 32'h333);
        idle(0);
        check("s_drain0_wa", rf_wa, 10);
        check("s_drain0_wd", rf_wd, 32'hA0A0);
        idle(0);
        check("s_drain1_we", rf_we, 1);
        check("s_drain1_wa", rf_wa, 11);
        check("s_drain1_wd", rf_wd, 32'hB0B0);
        idle(0);
        check("s_drain_done_we", rf_we, 0);

        // ---- writes to r0 are suppressed but still drain ----
        cycle(1, 5'd0, 32'h5555, 1, 5'd0, 32'h6666, 0, 0, 0, 0, 0);
        check("s_r0_alu_we", rf_we, 0);
        idle(0);
        check("s_r0_lsu_we", rf_we, 0);
        check("s_r0_drained", lsu_ready, 1);

        // ---- set beats clear; double long issue flags sb_err ----
        cycle(0, 0, 0, 0, 0, 0, 1, 5'd3, 1, 0, 0);
        cycle(0, 0, 0, 1, 5'd3, 32'h33, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 5'd3, 1, 5'd3, 0);
        check("s_sb_pop_we", rf_we, 1);
        check("s_sb_pop_wa", rf_wa, 3);
        check("s_sb_busy_kept", hazard, 1);
        cycle(0, 0, 0, 0, 0, 0, 1, 5'd3, 1, 5'd3, 0);
        check("s_sb_err", sb_err, 1);

        // ---- reset with two buffered entries ----
        cycle(1, 5'd1, 32'h1, 1, 5'd20, 32'h20, 1, 5'd20, 1, 0, 0);
        cycle(1, 5'd2, 32'h2, 1, 5'd21, 32'h21, 0, 0, 0, 0, 0);
        alu_valid = 0; lsu_valid = 0; issue_valid = 0; chk_ra0 = 5'd20;
        rst = 1'b1;
        #1;
        check("s_rst_we", rf_we, 0);
        check("s_rst_wa", rf_wa, 0);
        check("s_rst_wd", rf_wd, 0);
        check("s_rst_ready", lsu_ready, 0);
        check("s_rst_hold", alu_hold, 0);
        check("s_rst_sb", sb_err, 0);
        check("s_rst_hazard", hazard, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("s_rel_ready", lsu_ready, 1);
        @(posedge clk);
        #1;
        check("s_rel_no_write", rf_we, 0);
        idle(0);
        check("s_rel_idle_we", rf_we, 0);

        // ---- randomized run against the model ----
        for (int n = 0; n < 400; n++) begin
            av  = ($urandom_range(0, 1) == 1);
            lv  = ($urandom_range(0, 2) != 0);
            iv  = ($urandom_range(0, 3) == 0);
            il  = ($urandom_range(0, 1) == 1);
            ird = 5'($urandom_range(0, 31));
            if (m_busy[ird]) il = 1'b0;
            cycle(av, 5'($urandom_range(0, 31)), $urandom,
                  lv, 5'($urandom_range(0, 31)), $urandom,
                  iv, ird, il,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data width of result and register-file write data.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have ports alu_valid/alu_rd/alu_data, input, 1/5/WIDTH, single-cycle result; always accepted.
REQ-005 SHALL have ports lsu_valid/lsu_rd/lsu_data, input, 1/5/WIDTH, long-latency (load/muldiv) result; offered under valid/ready.
REQ-006 SHALL have port lsu_ready, output, 1, meaning an lsu result can be accepted this cycle.
REQ-007 SHALL have ports issue_valid/issue_rd/issue_long, input, 1/5/1, meaning an instruction issues whose rd is produced by the long-latency path.
REQ-008 SHALL have ports chk_ra0/chk_ra1, input, 5 each, the source registers of the instruction about to issue.
REQ-009 SHALL have port hazard, output, 1, combinational: chk_ra0 or chk_ra1 (non-zero) is busy.
REQ-010 SHALL have port alu_hold, output, 1, meaning the pipeline must not present alu_valid next cycle (buffer full).
REQ-011 SHALL have ports rf_we/rf_wa/rf_wd, output, 1/5/WIDTH, registered write port driving the register file.
REQ-012 SHALL have port sb_err, output, 1, sticky flag for a long issue to an already-busy rd.

Function
REQ-013 SHALL accept an lsu result when lsu_valid && lsu_ready, pushing {rd,data} into a 2-entry FIFO.
REQ-014 SHALL drive lsu_ready = FIFO not full; alu_hold = FIFO full.
REQ-015 SHALL arbitrate each cycle: alu_valid has priority; else FIFO head is popped when non-empty.
REQ-016 SHALL register the selected write: rf_we/rf_wa/rf_wd valid exactly 1 cycle after alu_valid or FIFO pop.
REQ-017 SHALL force rf_we = 0 when the selected rd is 0; the FIFO entry is still popped.
REQ-018 SHALL hold rf_we = 0 in idle cycles; rf_wa/rf_wd keep last value.
REQ-019 SHALL accept push and pop in the same cycle when full-with-pop (lsu_ready evaluated before pop, i.e. full => not ready).
REQ-020 SHALL keep a 32-bit busy scoreboard: set busy[issue_rd] on issue_valid && issue_long && issue_rd != 0.
REQ-021 SHALL clear busy[rd] in the cycle the FIFO entry for rd is popped (register committed next edge).
REQ-022 SHALL give set priority over clear when both address the same rd in one cycle.
REQ-023 SHALL set sb_err when a long issue targets an rd whose busy bit is already 1; cleared only by reset.
REQ-024 SHALL treat register 0 as never busy.
REQ-025 SHALL not reorder lsu results; FIFO is strictly in-order.

Reset
REQ-026 SHALL on rst clear rf_we, rf_wa, rf_wd, busy, sb_err, FIFO pointers/count; lsu_ready = 0 and alu_hold = 0 while rst high.
REQ-027 SHALL discard buffered results on reset mid-operation; no rf_we pulse in the cycle after rst deasserts.

Structure
REQ-028 SHALL take NUM_REGS = 32, REG_ADDR_W = 5, WB_FIFO_DEPTH = 2 from the shared pCPU package.
REQ-029 SHALL implement the buffer as sub-module wb_skid_fifo (push/pop/full/empty/head).
REQ-030 SHALL contain no combinational path from lsu_valid to lsu_ready.

Verification
REQ-031 SHALL cover: alu_valid, rd=5, data=0x12345678 -> next cycle rf_we=1, rf_wa=5, rf_wd=0x12345678.
REQ-032 SHALL cover: issue long rd=7 then chk_ra0=7 -> hazard=1; lsu result rd=7 data=0xA5 with alu idle -> rf write 0xA5 to 7 next cycle, hazard=0 after.
REQ-033 SHALL cover: alu_valid held 3 cycles while lsu pushes 2 results -> lsu_ready=0, alu_hold=1; after alu drops, both written in order on consecutive cycles.
REQ-034 SHALL cover: alu rd=0 and lsu rd=0 -> rf_we stays 0; FIFO drains.
REQ-035 SHALL cover: issue long rd=3 same cycle as pop of rd=3 -> busy[3] remains 1; second long issue to rd=3 -> sb_err=1.
REQ-036 SHALL cover: rst asserted with 2 entries buffered -> outputs zero immediately, no write after release, lsu_ready=1 next cycle.
